// File: rtl/spike_compressor_temporal_mc.sv
// spike_compressor_temporal_mc
//   Collects per-channel spike bits over a window of T_WINDOW accepted
//   timesteps and emits each window as one frame on a valid/ready output.
//   The frame holds the packed patterns, the per-channel spike counts, the
//   window length and a frame id. A flush emits a partial window early.
//   Storage is one accumulator plus one output register. When the output
//   register cannot take a finished frame, the accumulator keeps it (HOLD)
//   until the output register drains.
//
// Ports
//   clk          clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   spike_in     one spike bit per channel for the current timestep
//   spike_valid  spike_in is valid; accepted when spike_valid && in_ready
//   flush        request emission of the partial frame
//   in_ready     a timestep can be accepted this cycle (registered state only)
//   out_valid    output frame valid
//   out_ready    consumer takes the frame when out_valid && out_ready
//   out_pattern  channel c at [c*T_WINDOW +: T_WINDOW], bit 0 = newest step
//   out_count    channel c spike count at [c*CNT_W +: CNT_W]
//   out_len      number of timesteps in the frame
//   out_id       frame sequence number, wraps modulo 2^ID_W
//   drop_err     sticky: spike_valid was seen while in_ready was 0
module spike_compressor_temporal_mc #(
  parameter int N_CH     = 4,
  parameter int T_WINDOW = 16,
  parameter int ID_W     = 8,
  localparam int CNT_W   = $clog2(T_WINDOW + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            spike_in,
  input  logic                       spike_valid,
  input  logic                       flush,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_CH*T_WINDOW-1:0]   out_pattern,
  output logic [N_CH*CNT_W-1:0]      out_count,
  output logic [CNT_W-1:0]           out_len,
  output logic [ID_W-1:0]            out_id,
  output logic                       drop_err
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [N_CH*T_WINDOW-1:0]   acc_pat_q, pat_upd;
  logic [N_CH*CNT_W-1:0]      acc_cnt_q, cnt_upd;
  logic [CNT_W-1:0]           step_q, step_upd;
  logic [ID_W-1:0]            frame_id_q;
  logic                       out_valid_q;
  logic [N_CH*T_WINDOW-1:0]   out_pattern_q;
  logic [N_CH*CNT_W-1:0]      out_count_q;
  logic [CNT_W-1:0]           out_len_q;
  logic [ID_W-1:0]            out_id_q;
  logic                       drop_err_q;

  logic accept;
  logic out_free;
  logic emit;
  logic load_out;

  assign accept   = spike_valid && (state_q == COLLECT);
  assign out_free = !out_valid_q || out_ready;

  // Accumulator contents after this cycle's accept. In HOLD there is never an
  // accept, so these equal the held frame. This lets both states load the
  // output register from the same source.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign pat_upd[gi*T_WINDOW +: T_WINDOW] = accept
          ? {acc_pat_q[gi*T_WINDOW +: T_WINDOW-1], spike_in[gi]}
          : acc_pat_q[gi*T_WINDOW +: T_WINDOW];
      assign cnt_upd[gi*CNT_W +: CNT_W] = acc_cnt_q[gi*CNT_W +: CNT_W]
          + (accept ? CNT_W'(spike_in[gi]) : CNT_W'(0));
    end
  endgenerate

  assign step_upd = step_q + (accept ? CNT_W'(1) : CNT_W'(0));

  // A frame is finished either when the window fills or on a flush. A flush
  // finishes a frame only if the frame would contain at least one step.
  assign emit = (state_q == COLLECT)
             && ((accept && (step_upd == CNT_W'(T_WINDOW)))
              || (flush && ((step_q != '0) || accept)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (emit && !out_free) state_d = HOLD;
      HOLD:    if (out_free)          state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = 1'b0;
    load_out = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        load_out = emit && out_free;
      end
      HOLD: load_out = out_free;
      default: ;
    endcase
  end

  // Accumulator, frame id and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_pat_q     <= '0;
      acc_cnt_q     <= '0;
      step_q        <= '0;
      frame_id_q    <= '0;
      out_valid_q   <= 1'b0;
      out_pattern_q <= '0;
      out_count_q   <= '0;
      out_len_q     <= '0;
      out_id_q      <= '0;
      drop_err_q    <= 1'b0;
    end else begin
      if (load_out) begin
        acc_pat_q     <= '0;
        acc_cnt_q     <= '0;
        step_q        <= '0;
        frame_id_q    <= frame_id_q + ID_W'(1);
        out_valid_q   <= 1'b1;
        out_pattern_q <= pat_upd;
        out_count_q   <= cnt_upd;
        out_len_q     <= step_upd;
        out_id_q      <= frame_id_q;
      end else begin
        acc_pat_q <= pat_upd;
        acc_cnt_q <= cnt_upd;
        step_q    <= step_upd;
        if (out_ready) out_valid_q <= 1'b0;
      end
      if (spike_valid && !in_ready) drop_err_q <= 1'b1;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pattern = out_pattern_q;
  assign out_count   = out_count_q;
  assign out_len     = out_len_q;
  assign out_id      = out_id_q;
  assign drop_err    = drop_err_q;

endmodule
